mod_counter_ctrl: RTL and testbench
===================================

MOD_COUNTER_CTRL -- requirements
Module: mod_counter_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 3, counter width in bits (terminal value range 0..2**WIDTH-1).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port: cfg_valid  input  1  configuration offered.
REQ-005 SHALL have port: cfg_ready  output  1  configuration accepted this cycle if cfg_valid=1.
REQ-006 SHALL have port: cfg_term  input  WIDTH  terminal count (modulus minus 1).
REQ-007 SHALL have port: cfg_oneshot  input  1  1 = stop after one period, 0 = continuous.
REQ-008 SHALL have port: start  input  1  begin or resume counting.
REQ-009 SHALL have port: pause  input  1  hold count.
REQ-010 SHALL have port: stop  input  1  abort, return to IDLE.
REQ-011 SHALL have port: count  output  WIDTH  current count.
REQ-012 SHALL have port: busy  output  1  high in RUN or PAUSE.
REQ-013 SHALL have port: wrap  output  1  one-cycle pulse after rollover to 0 in continuous mode.
REQ-014 SHALL have port: done  output  1  one-cycle pulse on first DONE cycle.
REQ-015 SHALL have port: state  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.

Function
REQ-016 SHALL accept configuration on cfg_valid & cfg_ready; cfg_ready = 1 only in IDLE or DONE; registered term/oneshot update at that edge.
REQ-017 SHALL, in IDLE, hold count=0; start -> RUN at next edge; count becomes 1 one edge later (start-to-first-increment latency 2 edges).
REQ-018 SHALL, in RUN, increment count by 1 each edge; when count==term, next edge sets count=0.
REQ-019 SHALL, on rollover with oneshot=0, remain in RUN and assert wrap (registered) for exactly the cycle count shows 0.
REQ-020 SHALL, on rollover with oneshot=1, enter DONE with count=0, done high that cycle only, wrap low.
REQ-021 SHALL apply priority stop > pause > start/advance each cycle.
REQ-022 SHALL, on stop in RUN, PAUSE or DONE, go to IDLE with count=0 at next edge.
REQ-023 SHALL, on pause in RUN, go to PAUSE holding count; PAUSE -> RUN when start=1 and pause=0; counting resumes from held value one edge later.
REQ-024 SHALL, in DONE, hold count=0 until start (-> RUN) or stop (-> IDLE).
REQ-025 SHALL ignore start in RUN and cfg_valid while busy (term unchanged).
REQ-026 SHALL, with term=0, keep count=0 in RUN; continuous: wrap high every RUN cycle after the first; oneshot: DONE after first RUN edge.
REQ-027 SHALL implement count as synchronous T flip-flops: T[0]=en, T[i]=en & q[i-1:0] all ones; no ripple clocks.

Reset
REQ-028 SHALL, while reset=0 at a rising edge: state=IDLE, count=0, wrap=0, done=0, busy=0, term=2**WIDTH-1, oneshot=0; cfg_ready=1 after reset.
REQ-029 SHALL let reset override all inputs, including mid-RUN or PAUSE.

Structure
REQ-030 SHALL place state encoding type and state constants, plus WIDTH default, in shared package mod_counter_pkg.
REQ-031 SHALL instantiate one sub-module t_counter_en: WIDTH-bit T-flip-flop counter with en and synchronous clr inputs.

Verification (WIDTH=3)
REQ-032 SHALL check: reset=0 for 3 cycles, release, start without cfg -> count 1..7,0,1; wrap high only at the 0; cfg_ready=0 while busy.
REQ-033 SHALL check: cfg_term=4, cfg_oneshot=1, start -> count 1,2,3,4,0; state DONE at 0; done one cycle; busy 0.
REQ-034 SHALL check: cfg_term=2 continuous -> count 1,2,0,1,2,0; wrap exactly at each 0 following 2.
REQ-035 SHALL check: pause at count=3 for 4 cycles -> count 3, state PAUSE; then start, pause=0 -> next RUN counts 4.
REQ-036 SHALL check: stop and pause together at count=5 -> IDLE, count 0; cfg_valid with term=1 during RUN -> not accepted, period stays 8.
REQ-037 SHALL check: reset=0 mid-RUN at count=6 -> next edge IDLE, count 0, term restored to 7; term=0 continuous -> wrap every cycle.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// Shared types and defaults for the modulo counter controller.
// State encoding is visible on the state output port.
package mod_counter_pkg;

    localparam int WIDTH_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/t_counter_en.sv
// Synchronous T-flip-flop up counter with enable and clear.
// Bit i toggles when en is high and all lower bits are ones.
module t_counter_en #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] t;

    always_comb begin : tgen
        logic carry;
        carry = en;
        for (int i = 0; i < WIDTH; i++) begin
            t[i]  = carry;
            carry = carry & q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else begin
            q <= q ^ t;
        end
    end

endmodule

// File: rtl/mod_counter_ctrl.sv
// Run/pause/stop controller around a configurable modulo counter.
// Priority each cycle is stop > pause > start/advance.
module mod_counter_ctrl
    import mod_counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_term,
    input  logic             cfg_oneshot,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             wrap,
    output logic             done,
    output logic [1:0]       state
);

    state_t           state_q;
    state_t           state_n;
    logic [WIDTH-1:0] term_q;
    logic             oneshot_q;
    logic             wrap_q;
    logic             wrap_n;
    logic             done_q;
    logic             done_n;
    logic             cnt_en;
    logic             cnt_clr;
    logic             resume;

    assign resume    = start & ~pause;
    assign cfg_ready = (state_q == ST_IDLE) | (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN) | (state_q == ST_PAUSE);
    assign wrap      = wrap_q;
    assign done      = done_q;
    assign state     = state_q;

    always_comb begin
        state_n = state_q;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        wrap_n  = 1'b0;
        done_n  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (!stop && resume) state_n = ST_RUN;
            end
            ST_RUN: begin
                if (stop) begin
                    state_n = ST_IDLE;
                    cnt_clr = 1'b1;
                end else if (pause) begin
                    state_n = ST_PAUSE;
                end else if (count == term_q) begin
                    cnt_clr = 1'b1;
                    if (oneshot_q) begin
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                    end else begin
                        wrap_n = 1'b1;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_n = ST_IDLE;
                    cnt_clr = 1'b1;
                end else if (resume) begin
                    state_n = ST_RUN;
                end
            end
            ST_DONE: begin
                cnt_clr = 1'b1;
                if (stop) state_n = ST_IDLE;
                else if (resume) state_n = ST_RUN;
            end
            default: begin
                state_n = ST_IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
            term_q    <= '1;
            oneshot_q <= 1'b0;
        end else begin
            state_q <= state_n;
            wrap_q  <= wrap_n;
            done_q  <= done_n;
            if (cfg_valid && cfg_ready) begin
                term_q    <= cfg_term;
                oneshot_q <= cfg_oneshot;
            end
        end
    end

    t_counter_en #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk(clk),
        .clr(cnt_clr | ~reset),
        .en (cnt_en),
        .q  (count)
    );

endmodule

// File: tb/tb_mod_counter_ctrl.sv
// Scenario and randomized bench for mod_counter_ctrl (WIDTH=3).
module tb_mod_counter_ctrl;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         cfg_valid = 1'b0;
    logic         cfg_oneshot = 1'b0;
    logic [W-1:0] cfg_term = '0;
    logic         start = 1'b0;
    logic         pause = 1'b0;
    logic         stop = 1'b0;
    logic         cfg_ready;
    logic [W-1:0] count;
    logic         busy;
    logic         wrap;
    logic         done;
    logic [1:0]   state;

    int tests = 0;
    int fails = 0;

    // Reference model: 0=IDLE 1=RUN 2=PAUSE 3=DONE
    int m_st = 0;
    int m_cnt = 0;
    int m_term = (1 << W) - 1;
    bit m_one = 1'b0;
    bit m_wrap = 1'b0;
    bit m_done = 1'b0;

    mod_counter_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_term(cfg_term), .cfg_oneshot(cfg_oneshot),
        .start(start), .pause(pause), .stop(stop),
        .count(count), .busy(busy), .wrap(wrap),
        .done(done), .state(state)
    );

    always #5 clk = ~clk;

    function automatic void model_step();
        int old_st;
        int nxt;
        if (!reset) begin
            m_st = 0; m_cnt = 0; m_wrap = 0; m_done = 0;
            m_term = (1 << W) - 1; m_one = 0;
            return;
        end
        old_st = m_st;
        m_wrap = 0;
        m_done = 0;
        if (stop) begin
            m_st = 0;
            m_cnt = 0;
        end else if (old_st == 1 && pause) begin
            m_st = 2;
        end else if (old_st == 1) begin
            nxt = (m_cnt + 1) % (m_term + 1);
            m_cnt = nxt;
            if (nxt == 0 && m_one) begin
                m_st = 3; m_done = 1;
            end else if (nxt == 0) begin
                m_wrap = 1;
            end
        end else if (start && !pause) begin
            m_st = 1;
        end
        if (cfg_valid && (old_st == 0 || old_st == 3)) begin
            m_term = int'(cfg_term);
            m_one = cfg_oneshot;
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input int term, input bit one);
        cfg_valid = 1; cfg_term = W'(term); cfg_oneshot = one;
        tick();
        cfg_valid = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        repeat (3) tick();
        tests++;
        if (state !== 2'd0 || count !== 3'd0) begin
            fails++;
            $display("FAIL reset_state: state=%0d count=%0d want 0/0", state, count);
        end
        tests++;
        if (wrap !== 0 || done !== 0 || busy !== 0) begin
            fails++;
            $display("FAIL reset_flags: wrap=%b done=%b busy=%b want 000", wrap, done, busy);
        end
        reset = 1;
        tick();
        tests++;
        if (cfg_ready !== 1 || state !== 2'd0) begin
            fails++;
            $display("FAIL reset_ready: ready=%b state=%0d want 1/0", cfg_ready, state);
        end
    endtask

    task automatic test_default_count();
        int exp;
        start = 1;
        tick();
        start = 0;
        tests++;
        if (state !== 2'd1 || count !== 3'd0 || busy !== 1) begin
            fails++;
            $display("FAIL start_latency: state=%0d count=%0d busy=%b want 1/0/1", state, count, busy);
        end
        for (int i = 1; i <= 9; i++) begin
            tick();
            exp = i % 8;
            tests++;
            if (count !== W'(exp) || wrap !== (exp == 0) || cfg_ready !== 0) begin
                fails++;
                $display("FAIL default_count: count=%0d wrap=%b ready=%b want %0d/%b/0",
                         count, wrap, cfg_ready, exp, exp == 0);
            end
        end
        stop = 1;
        tick();
        stop = 0;
        tests++;
        if (state !== 2'd0 || count !== 3'd0) begin
            fails++;
            $display("FAIL stop_run: state=%0d count=%0d want 0/0", state, count);
        end
    endtask

    task automatic test_oneshot();
        int exp;
        configure(4, 1);
        start = 1;
        tick();
        start = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            exp = i % 5;
            tests++;
            if (count !== W'(exp) || state !== (exp == 0 ? 2'd3 : 2'd1)
                || done !== (exp == 0) || wrap !== 0) begin
                fails++;
                $display("FAIL oneshot_seq: count=%0d state=%0d done=%b wrap=%b at step %0d",
                         count, state, done, wrap, i);
            end
        end
        tests++;
        if (busy !== 0) begin
            fails++;
            $display("FAIL oneshot_busy: got %b want 0", busy);
        end
        tick();
        tests++;
        if (done !== 0 || state !== 2'd3 || count !== 3'd0) begin
            fails++;
            $display("FAIL oneshot_hold: done=%b state=%0d count=%0d want 0/3/0", done, state, count);
        end
    endtask

    task automatic test_term2();
        int exp;
        configure(2, 0);
        tests++;
        if (state !== 2'd3) begin
            fails++;
            $display("FAIL cfg_in_done: state=%0d want 3", state);
        end
        start = 1;
        tick();
        start = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            exp = i % 3;
            tests++;
            if (count !== W'(exp) || wrap !== (exp == 0)) begin
                fails++;
                $display("FAIL term2_seq: count=%0d wrap=%b want %0d/%b", count, wrap, exp, exp == 0);
            end
        end
        stop = 1;
        tick();
        stop = 0;
    endtask

    task automatic test_pause();
        configure(7, 0);
        start = 1;
        tick();
        start = 0;
        repeat (3) tick();
        pause = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (count !== 3'd3 || state !== 2'd2 || busy !== 1) begin
                fails++;
                $display("FAIL pause_hold: count=%0d state=%0d busy=%b want 3/2/1", count, state, busy);
            end
        end
        pause = 0;
        start = 1;
        tick();
        start = 0;
        tests++;
        if (state !== 2'd1 || count !== 3'd3) begin
            fails++;
            $display("FAIL resume: state=%0d count=%0d want 1/3", state, count);
        end
        tick();
        tests++;
        if (count !== 3'd4) begin
            fails++;
            $display("FAIL resume_count: count=%0d want 4", count);
        end
    endtask

    task automatic test_stop_pause();
        int exp;
        cfg_valid = 1; cfg_term = 3'd1;
        tests++;
        if (cfg_ready !== 0) begin
            fails++;
            $display("FAIL busy_ready: got %b want 0", cfg_ready);
        end
        tick();
        cfg_valid = 0;
        stop = 1; pause = 1;
        tick();
        stop = 0; pause = 0;
        tests++;
        if (state !== 2'd0 || count !== 3'd0) begin
            fails++;
            $display("FAIL stop_over_pause: state=%0d count=%0d want 0/0", state, count);
        end
        start = 1;
        tick();
        start = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp = i % 8;
            tests++;
            if (count !== W'(exp)) begin
                fails++;
                $display("FAIL period8: count=%0d want %0d", count, exp);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int exp;
        stop = 1;
        tick();
        stop = 0;
        configure(6, 0);
        start = 1;
        tick();
        start = 0;
        repeat (6) tick();
        tests++;
        if (count !== 3'd6) begin
            fails++;
            $display("FAIL pre_reset: count=%0d want 6", count);
        end
        reset = 0;
        start = 1;
        tick();
        reset = 1;
        start = 0;
        tests++;
        if (state !== 2'd0 || count !== 3'd0 || busy !== 0) begin
            fails++;
            $display("FAIL mid_reset: state=%0d count=%0d busy=%b", state, count, busy);
        end
        start = 1;
        tick();
        start = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp = i % 8;
            tests++;
            if (count !== W'(exp) || wrap !== (exp == 0)) begin
                fails++;
                $display("FAIL term_restored: count=%0d wrap=%b want %0d", count, wrap, exp);
            end
        end
    endtask

    task automatic test_term0();
        stop = 1;
        tick();
        stop = 0;
        configure(0, 0);
        start = 1;
        tick();
        start = 0;
        tests++;
        if (state !== 2'd1 || count !== 3'd0 || wrap !== 0) begin
            fails++;
            $display("FAIL term0_first: state=%0d count=%0d wrap=%b", state, count, wrap);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (state !== 2'd1 || count !== 3'd0 || wrap !== 1) begin
                fails++;
                $display("FAIL term0_wrap: state=%0d count=%0d wrap=%b want 1/0/1", state, count, wrap);
            end
        end
        stop = 1;
        tick();
        stop = 0;
        configure(0, 1);
        start = 1;
        tick();
        start = 0;
        tick();
        tests++;
        if (state !== 2'd3 || done !== 1 || wrap !== 0) begin
            fails++;
            $display("FAIL term0_oneshot: state=%0d done=%b wrap=%b want 3/1/0", state, done, wrap);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            reset       = ($urandom_range(0, 99) != 0);
            stop        = ($urandom_range(0, 19) == 0);
            pause       = ($urandom_range(0, 5) == 0);
            start       = ($urandom_range(0, 3) == 0);
            cfg_valid   = ($urandom_range(0, 3) == 0);
            cfg_term    = W'($urandom);
            cfg_oneshot = ($urandom_range(0, 2) == 0);
            tick();
            tests++;
            if (state !== 2'(m_st) || count !== W'(m_cnt) || wrap !== m_wrap
                || done !== m_done || busy !== (m_st == 1 || m_st == 2)
                || cfg_ready !== (m_st == 0 || m_st == 3)) begin
                fails++;
                $display("FAIL random[%0d]: st=%0d cnt=%0d w=%b d=%b want st=%0d cnt=%0d w=%b d=%b",
                         i, state, count, wrap, done, m_st, m_cnt, m_wrap, m_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_count();
        test_oneshot();
        test_term2();
        test_pause();
        test_stop_pause();
        test_reset_mid_run();
        test_term0();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
